ddc_ctrl: RTL and testbench

//  Sequencing controller for the DDC chain (tuner -> CIC -> FIR). Owns the DDC reset and the NCO tuning word.

---
 rtl/ddc_pkg.sv | 14 +
 rtl/ddc_ctrl_fifo.sv | 51 +++++
 rtl/ddc_ctrl.sv | 125 ++++++++++++
 tb/tb_ddc_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// Shared constants and FSM encoding for the DDC chain and its sequencing controller.
package ddc_pkg;

    localparam int DDC_FSZ = 26;
    localparam int DDC_OSZ = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESET  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } ddc_state_e;

endpackage

// File: rtl/ddc_ctrl_fifo.sv
// Small synchronous FIFO for settled I/Q pairs; head is taken straight from registers.
module ddc_ctrl_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_en, rd_en;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && valid;
    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddc_ctrl.sv
// DDC sequencing controller: owns DDC reset and tuning word, flushes on retune,
// discards settling samples and buffers settled I/Q toward a valid/ready consumer.
module ddc_ctrl
    import ddc_pkg::*;
#(
    parameter int FSZ        = DDC_FSZ,
    parameter int OSZ        = DDC_OSZ,
    parameter int RST_CYCLES = 4,
    parameter int SETTLE     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  cfg_wr,
    input  logic [FSZ-1:0]        cfg_freq,
    input  logic                  cfg_ns_en,
    output logic                  cfg_busy,
    output logic                  running,
    output logic                  ddc_reset,
    output logic [FSZ-1:0]        ddc_lo_freq,
    output logic                  ddc_lo_ns_en,
    input  logic                  ddc_valid,
    input  logic signed [OSZ-1:0] ddc_i,
    input  logic signed [OSZ-1:0] ddc_q,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [OSZ-1:0] m_i,
    output logic signed [OSZ-1:0] m_q,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int CMAX = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
    localparam int CW   = $clog2(CMAX);

    ddc_state_e     state, next_state;
    logic [CW-1:0]  cnt;
    logic           load_cfg, cnt_clr, flush;
    logic           push, pop, drop, fifo_full;
    logic [FSZ-1:0] pend_freq;
    logic           pend_ns_en;
    logic [2*OSZ-1:0] fifo_dout;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (enable) next_state = ST_RESET;
            ST_RESET:  if (cnt == CW'(RST_CYCLES-1)) next_state = ST_SETTLE;
            ST_SETTLE: if (ddc_valid && cnt == CW'(SETTLE-1)) next_state = ST_RUN;
            ST_RUN:    next_state = ST_RUN;
            default:   next_state = ST_IDLE;
        endcase
        // A retune restarts the flush; dropping enable overrides everything.
        if (cfg_wr && state != ST_IDLE) next_state = ST_RESET;
        if (!enable) next_state = ST_IDLE;
    end

    assign load_cfg = (next_state == ST_RESET) && ((state != ST_RESET) || cfg_wr);
    assign cnt_clr  = (next_state != state) || load_cfg;
    assign flush    = (next_state == ST_IDLE) || load_cfg;
    assign push     = (state == ST_RUN) && (next_state == ST_RUN) && ddc_valid;
    assign pop      = m_valid && m_ready;
    assign drop     = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (cnt_clr)
                cnt <= '0;
            else if (state == ST_RESET || (state == ST_SETTLE && ddc_valid))
                cnt <= cnt + CW'(1);
        end
    end

    // The word written in the same cycle as a retune is the one applied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_freq    <= '0;
            pend_ns_en   <= 1'b0;
            ddc_lo_freq  <= '0;
            ddc_lo_ns_en <= 1'b0;
        end else begin
            if (cfg_wr) begin
                pend_freq  <= cfg_freq;
                pend_ns_en <= cfg_ns_en;
            end
            if (load_cfg) begin
                ddc_lo_freq  <= cfg_wr ? cfg_freq  : pend_freq;
                ddc_lo_ns_en <= cfg_wr ? cfg_ns_en : pend_ns_en;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    assign ddc_reset = (state == ST_IDLE) || (state == ST_RESET);
    assign cfg_busy  = (state == ST_RESET) || (state == ST_SETTLE);
    assign running   = (state == ST_RUN);

    ddc_ctrl_fifo #(
        .W     (2*OSZ),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .din     ({ddc_i, ddc_q}),
        .dout    (fifo_dout),
        .valid   (m_valid),
        .full    (fifo_full)
    );

    assign {m_i, m_q} = fifo_dout;

endmodule

// File: tb/tb_ddc_ctrl.sv
// Directed bench for ddc_ctrl: per-cycle comparison against a queue-based behavioural
// model, plus literal expectations at the key points of each scenario.
module tb_ddc_ctrl;

    localparam int FSZ = 26;
    localparam int OSZ = 16;
    localparam int RSTC = 4;
    localparam int SETL = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n, enable, cfg_wr, cfg_ns_en, ddc_valid, m_ready, ovf_clr;
    logic [FSZ-1:0] cfg_freq;
    logic signed [OSZ-1:0] ddc_i, ddc_q;
    logic cfg_busy, running, ddc_reset, ddc_lo_ns_en, m_valid, overflow;
    logic [FSZ-1:0] ddc_lo_freq;
    logic signed [OSZ-1:0] m_i, m_q;

    ddc_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cfg_wr       (cfg_wr),
        .cfg_freq     (cfg_freq),
        .cfg_ns_en    (cfg_ns_en),
        .cfg_busy     (cfg_busy),
        .running      (running),
        .ddc_reset    (ddc_reset),
        .ddc_lo_freq  (ddc_lo_freq),
        .ddc_lo_ns_en (ddc_lo_ns_en),
        .ddc_valid    (ddc_valid),
        .ddc_i        (ddc_i),
        .ddc_q        (ddc_q),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_i          (m_i),
        .m_q          (m_q),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=parked, 1=flushing, 2=settling, 3=running.
    int ph = 0;
    int rst_left = 0;
    int settle_left = 0;
    logic [FSZ-1:0] pend_f = '0, lo_f = '0;
    logic pend_ns = 1'b0, lo_ns = 1'b0, m_ovf = 1'b0;
    logic [31:0] q[$];

    always @(posedge clk or negedge reset_n) begin
        int np;
        bit enter_rst, drop;
        if (!reset_n) begin
            ph = 0; rst_left = 0; settle_left = 0;
            pend_f = '0; lo_f = '0; pend_ns = 1'b0; lo_ns = 1'b0; m_ovf = 1'b0;
            q.delete();
        end else begin
            np = ph; enter_rst = 1'b0; drop = 1'b0;
            if (!enable) np = 0;
            else if (cfg_wr && ph != 0) begin np = 1; enter_rst = 1'b1; end
            else begin
                case (ph)
                    0: begin np = 1; enter_rst = 1'b1; end
                    1: if (rst_left == 1) begin np = 2; settle_left = SETL; end
                       else rst_left--;
                    2: if (ddc_valid) begin
                           if (settle_left == 1) np = 3;
                           else settle_left--;
                       end
                    default: ;
                endcase
            end
            if (np == 0 || enter_rst) q.delete();
            else begin
                if (q.size() > 0 && m_ready) void'(q.pop_front());
                if (ph == 3 && np == 3 && ddc_valid) begin
                    if (q.size() < DEPTH) q.push_back({ddc_i, ddc_q});
                    else drop = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (enter_rst) begin
                rst_left = RSTC;
                lo_f  = cfg_wr ? cfg_freq  : pend_f;
                lo_ns = cfg_wr ? cfg_ns_en : pend_ns;
            end
            if (cfg_wr) begin pend_f = cfg_freq; pend_ns = cfg_ns_en; end
            ph = np;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ddc_reset", 32'(ddc_reset), 32'(ph <= 1));
            chk("cfg_busy", 32'(cfg_busy), 32'(ph == 1 || ph == 2));
            chk("running", 32'(running), 32'(ph == 3));
            chk("ddc_lo_freq", 32'(ddc_lo_freq), 32'(lo_f));
            chk("ddc_lo_ns_en", 32'(ddc_lo_ns_en), 32'(lo_ns));
            chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (q.size() > 0) begin
                chk("m_i", 32'($unsigned(m_i)), 32'(q[0][31:16]));
                chk("m_q", 32'($unsigned(m_q)), 32'(q[0][15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] qv);
        ddc_valid = 1'b1; ddc_i = i; ddc_q = qv;
        tick();
        ddc_valid = 1'b0;
    endtask

    task automatic count_reset(output int n);
        n = 0;
        while (ddc_reset === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic settle_all();
        for (int k = 0; k < SETL; k++) send(16'(k + 1), 16'(k + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; enable = 1'b0; cfg_wr = 1'b0; cfg_freq = '0; cfg_ns_en = 1'b0;
        ddc_valid = 1'b0; ddc_i = '0; ddc_q = '0; m_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        started = 1'b1;
        chk("rst_ddc_reset", 32'(ddc_reset), 32'd1);
        chk("rst_lo_freq", 32'(ddc_lo_freq), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_m_i", 32'($unsigned(m_i)), 32'd0);
        reset_n = 1'b1;
        tick();

        // Scenario 1: config written in IDLE, then start-up
        cfg_freq = 26'h0400000; cfg_ns_en = 1'b1; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        tick();
        chk("t1_idle_lo_unchanged", 32'(ddc_lo_freq), 32'd0);
        enable = 1'b1;
        tick();
        chk("t1_lo_freq", 32'(ddc_lo_freq), 32'h0400000);
        chk("t1_lo_ns_en", 32'(ddc_lo_ns_en), 32'd1);
        count_reset(n);
        chk("t1_reset_len", 32'(n), 32'd4);
        settle_all();
        chk("t1_running", 32'(running), 32'd1);
        chk("t1_settle_dropped", 32'(m_valid), 32'd0);
        send(16'h1234, 16'hFFFB);
        chk("t1_first_valid", 32'(m_valid), 32'd1);
        chk("t1_first_i", 32'($unsigned(m_i)), 32'h1234);
        chk("t1_first_q", 32'($unsigned(m_q)), 32'h0000FFFB);
        m_ready = 1'b1; tick(); m_ready = 1'b0;

        // Scenario 2: overflow on the fifth push, then ordered drain
        for (int k = 0; k < 5; k++) send(16'(100 + k), 16'(k));
        chk("t2_overflow_set", 32'(overflow), 32'd1);
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain_i", 32'($unsigned(m_i)), 32'(100 + k));
            tick();
        end
        m_ready = 1'b0;
        chk("t2_empty", 32'(m_valid), 32'd0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t2_ovf_cleared", 32'(overflow), 32'd0);

        // Scenario 3: full FIFO with simultaneous push and pop
        for (int k = 0; k < 4; k++) send(16'(200 + k), 16'(k));
        ddc_valid = 1'b1; ddc_i = 16'sd204; ddc_q = 16'sd4; m_ready = 1'b1;
        tick();
        ddc_valid = 1'b0;
        chk("t3_no_overflow", 32'(overflow), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            chk("t3_order_i", 32'($unsigned(m_i)), 32'(200 + k));
            tick();
        end
        m_ready = 1'b0;
        chk("t3_empty", 32'(m_valid), 32'd0);

        // Scenario 4: retune in RUN with queued samples
        send(16'd300, 16'd0); send(16'd301, 16'd0);
        cfg_freq = 26'h1555555; cfg_ns_en = 1'b0; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        chk("t4_flushed", 32'(m_valid), 32'd0);
        chk("t4_ddc_reset", 32'(ddc_reset), 32'd1);
        chk("t4_lo_freq", 32'(ddc_lo_freq), 32'h1555555);
        count_reset(n);
        chk("t4_reset_len", 32'(n), 32'd4);
        settle_all();
        chk("t4_settle_dropped", 32'(m_valid), 32'd0);
        send(16'h0777, 16'd1);
        chk("t4_resume_i", 32'($unsigned(m_i)), 32'h0777);
        m_ready = 1'b1; tick(); m_ready = 1'b0;

        // Scenario 5: repeated writes keep the DDC in reset
        for (int k = 0; k < 4; k++) begin
            cfg_freq = 26'h0100000 + 26'(k); cfg_wr = 1'b1;
            tick();
            cfg_wr = 1'b0;
            if (k < 3) begin tick(); tick(); end
        end
        count_reset(n);
        chk("t5_reset_after_last", 32'(n), 32'd4);
        chk("t5_last_word", 32'(ddc_lo_freq), 32'h0100003);
        settle_all();
        chk("t5_running", 32'(running), 32'd1);

        // Scenario 6a: enable dropped in RUN with overflow pending
        for (int k = 0; k < 5; k++) send(16'(400 + k), 16'(k));
        enable = 1'b0;
        tick();
        chk("t6_idle_running", 32'(running), 32'd0);
        chk("t6_idle_ddc_reset", 32'(ddc_reset), 32'd1);
        chk("t6_idle_m_valid", 32'(m_valid), 32'd0);
        for (int k = 0; k < 3; k++) send(16'(500 + k), 16'(k));
        chk("t6_idle_ovf_kept", 32'(overflow), 32'd1);
        chk("t6_idle_ignored", 32'(m_valid), 32'd0);

        // Scenario 6b: asynchronous reset while settling
        enable = 1'b1;
        tick();
        count_reset(n);
        send(16'd1, 16'd1); send(16'd2, 16'd2); send(16'd3, 16'd3);
        chk("t6_settling", 32'(cfg_busy), 32'd1);
        #2;
        reset_n = 1'b0; ddc_valid = 1'b1;
        #1;
        chk("t6_ar_ddc_reset", 32'(ddc_reset), 32'd1);
        chk("t6_ar_lo_freq", 32'(ddc_lo_freq), 32'd0);
        chk("t6_ar_overflow", 32'(overflow), 32'd0);
        chk("t6_ar_busy", 32'(cfg_busy), 32'd0);
        chk("t6_ar_m_valid", 32'(m_valid), 32'd0);
        tick();
        ddc_valid = 1'b0; enable = 1'b0;
        reset_n = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
